// File: rtl/qspi_mem_port_if.sv
// Request/response bus between the CPU memory path and the QSPI port.
// master = CPU side, slave = qspi_mem_port.
interface qspi_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_sel;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;

  modport master (
    output req_valid, req_write, req_sel, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_sel, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/qspi_mem_port.sv
// Single-byte QSPI memory port: opcode, 24-bit address, optional dummy
// turnaround and one data byte per request, flash on cs_rom_n, PSRAM on cs_ram_n.
module qspi_mem_port #(
  parameter int          DUMMY_CYCLES = 6,
  parameter logic [7:0]  CMD_READ     = 8'hEB,
  parameter logic [7:0]  CMD_WRITE    = 8'h38,
  parameter int          CS_HIGH_CLKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  qspi_mem_port_if.slave   bus,
  output logic             sclk,
  output logic             cs_rom_n,
  output logic             cs_ram_n,
  output logic [3:0]       io_out,
  output logic [3:0]       io_oe,
  input  logic [3:0]       io_in
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, CS_HIGH} state_t;

  typedef struct packed {
    logic        write;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } req_t;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] CSH_LAST   = (CS_HIGH_CLKS <= 1) ? 8'd0 : 8'(CS_HIGH_CLKS - 1);

  state_t     state, step_st;
  req_t       rq, req_in;
  logic [7:0] cnt, step_cnt;
  logic       phase;            // 0 = sclk low phase, 1 = sclk high phase
  logic [3:0] rd_hi;
  logic [3:0] step_oe, step_out;
  logic       rsp_valid_q;
  logic [7:0] rdata_q;

  assign req_in        = {bus.req_write, bus.req_addr, bus.req_wdata};
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

  // Pin values for SPI slot idx of state st: {oe, out}.
  function automatic logic [7:0] slot_drive(state_t st, logic [2:0] idx, req_t r);
    logic [7:0]  op_sh;
    logic [23:0] a_sh;
    logic [3:0]  o, e;
    o = '0;
    e = '0;
    op_sh = (r.write ? CMD_WRITE : CMD_READ) << idx;
    a_sh  = r.addr << {idx, 2'b00};
    case (st)
      CMD:  begin o = {3'b000, op_sh[7]}; e = 4'b0001; end
      ADDR: begin o = a_sh[23:20];         e = 4'b1111; end
      DATA: if (r.write) begin
              o = idx[0] ? r.wdata[3:0] : r.wdata[7:4];
              e = 4'b1111;
            end
      default: ;
    endcase
    return {e, o};
  endfunction

  // Slot that follows the current one once its high phase ends.
  always_comb begin
    step_st  = state;
    step_cnt = cnt + 8'd1;
    case (state)
      CMD:   if (cnt == 8'd7) begin step_st = ADDR; step_cnt = '0; end
      ADDR:  if (cnt == 8'd5) begin
               step_st  = (!rq.write && DUMMY_CYCLES > 0) ? DUMMY : DATA;
               step_cnt = '0;
             end
      DUMMY: if (cnt == DUMMY_LAST) begin step_st = DATA; step_cnt = '0; end
      DATA:  if (cnt == 8'd1) begin step_st = CS_HIGH; step_cnt = '0; end
      default: ;
    endcase
    {step_oe, step_out} = slot_drive(step_st, step_cnt[2:0], rq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rq          <= '0;
      cnt         <= '0;
      phase       <= 1'b0;
      rd_hi       <= '0;
      sclk        <= 1'b0;
      cs_rom_n    <= 1'b1;
      cs_ram_n    <= 1'b1;
      io_out      <= '0;
      io_oe       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          rq              <= req_in;
          state           <= CMD;
          cnt             <= '0;
          phase           <= 1'b0;
          sclk            <= 1'b0;
          cs_rom_n        <= bus.req_sel;
          cs_ram_n        <= !bus.req_sel;
          {io_oe, io_out} <= slot_drive(CMD, 3'd0, req_in);
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (!phase) begin
            phase <= 1'b1;
            sclk  <= 1'b1;
          end else begin
            phase <= 1'b0;
            sclk  <= 1'b0;
            state <= step_st;
            cnt   <= step_cnt;
            if (state == DATA && cnt == 8'd0) rd_hi <= io_in;
            if (step_st == CS_HIGH) begin
              cs_rom_n    <= 1'b1;
              cs_ram_n    <= 1'b1;
              io_oe       <= '0;
              io_out      <= '0;
              rsp_valid_q <= 1'b1;
              if (!rq.write) rdata_q <= {rd_hi, io_in};
            end else begin
              io_oe  <= step_oe;
              io_out <= step_out;
            end
          end
        end
        CS_HIGH: begin
          if (cnt == CSH_LAST) state <= IDLE;
          else                 cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
